img_bram_sched: RTL

//  Scheduler for the single-port 8-bit image BRAM (1-cycle registered read, read-first on write).

---
 rtl/img_ctrl_pkg.sv | 20 ++
 rtl/pix_skid_fifo.sv | 46 ++++
 rtl/img_bram_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/img_ctrl_pkg.sv
// rtl/img_ctrl_pkg.sv - shared types and defaults for the image BRAM scheduler
package img_ctrl_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One queued pixel plus the raster flags that travel with it.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  eol;
    logic                  last;
  } pix_entry_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// rtl/pix_skid_fifo.sv - 2-entry pixel FIFO absorbing BRAM read latency against stream stalls
module pix_skid_fifo
  import img_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  pix_entry_t din,
  output pix_entry_t head,
  output logic [1:0] cnt
);

  pix_entry_t mem [2];
  logic       wptr;
  logic       rptr;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/img_bram_sched.sv
// rtl/img_bram_sched.sv - single-port image BRAM scheduler: raster read stream plus arbitrated writeback
module img_bram_sched
  import img_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int SRC_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              pix_last,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  if (SRC_BASE + IMG_W * IMG_H > (1 << ADDR_W)) begin : g_bad_geom
    $error("img_bram_sched: image does not fit in ADDR_W from SRC_BASE");
  end
  if (IMG_W < 2 || IMG_H < 1) begin : g_bad_dims
    $error("img_bram_sched: IMG_W must be >= 2 and IMG_H >= 1");
  end
  if (DATA_W != DEF_DATA_W) begin : g_bad_width
    $error("img_bram_sched: DATA_W must match the pixel entry width");
  end

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              inflight;
  logic              inf_eol;
  logic              inf_last;
  logic              last_gnt_wr;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] din_hold;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  logic              pop;
  logic              push;
  logic              rd_req;
  logic              rd_go;
  logic              wr_go;
  logic              last_x;
  logic              last_rd;
  pix_entry_t        cap;
  pix_entry_t        head;

  pix_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .din   (cap),
    .head  (head),
    .cnt   (fifo_cnt)
  );

  assign busy      = (state != IDLE);
  assign pix_valid = (fifo_cnt != 2'd0);
  assign pix_data  = pix_valid ? head.data : '0;
  assign pix_eol   = pix_valid & head.eol;
  assign pix_last  = pix_valid & head.last;
  assign pop       = pix_valid & pix_ready;

  // Occupancy counts the read still in the BRAM pipe so the FIFO can never overflow.
  assign occ    = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign rd_req = (state == RUN) && !abort && (occ < 3'd2);

  // Contended cycles alternate; last_gnt_wr=0 after reset lets the writer win first.
  assign wr_go    = wr_valid && (!rd_req || !last_gnt_wr);
  assign rd_go    = rd_req && !wr_go;
  assign wr_ready = wr_go;
  assign ram_we   = wr_go;

  assign last_x  = (x == XW'(IMG_W - 1));
  assign last_rd = last_x && (y == YW'(IMG_H - 1));
  assign rd_addr = ADDR_W'(SRC_BASE + int'(y) * IMG_W + int'(x));

  assign ram_addr = wr_go ? wr_addr : (rd_go ? rd_addr : addr_hold);
  assign ram_din  = wr_go ? wr_data : din_hold;

  assign push = inflight && !abort;
  assign cap  = '{data: ram_dout, eol: inf_eol, last: inf_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      inflight    <= 1'b0;
      inf_eol     <= 1'b0;
      inf_last    <= 1'b0;
      last_gnt_wr <= 1'b0;
      addr_hold   <= '0;
      din_hold    <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_go || rd_go) addr_hold <= ram_addr;
      if (wr_go) din_hold <= wr_data;
      if (wr_valid && rd_req) last_gnt_wr <= wr_go;

      inflight <= rd_go;
      if (rd_go) begin
        inf_eol  <= last_x;
        inf_last <= last_rd;
      end

      if (abort) begin
        state    <= IDLE;
        inflight <= 1'b0;
        x        <= '0;
        y        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= RUN;
              x     <= '0;
              y     <= '0;
            end
          end
          RUN: begin
            if (rd_go) begin
              if (last_x) begin
                x <= '0;
                y <= y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
              if (last_rd) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (pop && head.last) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
